// File: rtl/pipeline_pkg.sv
// Shared encodings for the pipeline hazard controller.
package pipeline_pkg;

  // ALU operand source selects
  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // Multi-cycle EX occupancy tracker
  typedef enum logic {
    IDLE  = 1'b0,
    MULTI = 1'b1
  } hz_state_t;

endpackage

// File: rtl/pipeline_hazard_unit_fwd_select.sv
// One ALU operand's forwarding comparator: the EX/MEM result beats MEM/WB,
// and register 0 is never forwarded.
module fwd_select
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_enable,
  input  logic [REG_ADDR_W-1:0] i_src,
  input  logic [REG_ADDR_W-1:0] i_mem_rd,
  input  logic                  i_mem_regwrite,
  input  logic [REG_ADDR_W-1:0] i_wb_rd,
  input  logic                  i_wb_regwrite,
  output logic [1:0]            o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  assign w_mem_hit = i_mem_regwrite && (i_mem_rd != '0) && (i_mem_rd == i_src);
  assign w_wb_hit  = i_wb_regwrite  && (i_wb_rd  != '0) && (i_wb_rd  == i_src);

  // Priority select: newest producer first
  always_comb begin
    o_sel = FWD_REG;
    if (i_enable) begin
      if (w_mem_hit)     o_sel = FWD_EXMEM;
      else if (w_wb_hit) o_sel = FWD_MEMWB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Central stall/flush/forward controller for the 5-stage pipeline.
// Priority of pipeline control: multi-cycle stall > flush > load-use > advance.
module pipeline_hazard_unit
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [REG_ADDR_W-1:0] id_rs_i,
  input  logic [REG_ADDR_W-1:0] id_rt_i,
  input  logic                  id_uses_rt_i,
  input  logic [REG_ADDR_W-1:0] ex_rs_i,
  input  logic [REG_ADDR_W-1:0] ex_rt_i,
  input  logic [REG_ADDR_W-1:0] ex_rd_i,
  input  logic                  ex_memread_i,
  input  logic                  ex_multi_i,
  input  logic [REG_ADDR_W-1:0] mem_rd_i,
  input  logic                  mem_regwrite_i,
  input  logic [REG_ADDR_W-1:0] wb_rd_i,
  input  logic                  wb_regwrite_i,
  input  logic                  branch_taken_i,
  input  logic                  jump_i,
  output logic                  pc_write_o,
  output logic                  ifid_write_o,
  output logic                  ifid_flush_o,
  output logic                  idex_write_o,
  output logic                  idex_bubble_o,
  output logic                  exmem_bubble_o,
  output logic [1:0]            fwd_a_o,
  output logic [1:0]            fwd_b_o,
  output logic                  busy_o,
  output logic [CNT_W-1:0]      stall_cycles_o
);

  localparam int              CW       = $clog2(MULDIV_LAT + 1);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(MULDIV_LAT - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam bit              MULTI_EN = (MULDIV_LAT > 1);

  hz_state_t        r_state;
  hz_state_t        w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [CNT_W-1:0] r_stall_cycles;

  logic w_active;
  logic w_multi_stall;
  logic w_load_use;
  logic w_flush_req;

  assign w_active    = !rst_i && start_i;
  assign w_flush_req = branch_taken_i || jump_i;
  assign w_load_use  = ex_memread_i && (ex_rd_i != '0) &&
                       ((ex_rd_i == id_rs_i) || (id_uses_rt_i && (ex_rd_i == id_rt_i)));

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
    .i_enable      (w_active),
    .i_src         (ex_rs_i),
    .i_mem_rd      (mem_rd_i),
    .i_mem_regwrite(mem_regwrite_i),
    .i_wb_rd       (wb_rd_i),
    .i_wb_regwrite (wb_regwrite_i),
    .o_sel         (fwd_a_o)
  );

  fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
    .i_enable      (w_active),
    .i_src         (ex_rt_i),
    .i_mem_rd      (mem_rd_i),
    .i_mem_regwrite(mem_regwrite_i),
    .i_wb_rd       (wb_rd_i),
    .i_wb_regwrite (wb_regwrite_i),
    .o_sel         (fwd_b_o)
  );

  // State and occupancy counter; frozen whenever start_i is low
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state; the entry cycle stalls too, the final (cnt==1) cycle does not
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_multi_stall = 1'b0;
    if (start_i) begin
      unique case (r_state)
        IDLE: begin
          if (MULTI_EN && ex_multi_i) begin
            w_state_nxt   = MULTI;
            w_cnt_nxt     = CNT_LOAD;
            w_multi_stall = 1'b1;
          end
        end
        MULTI: begin
          w_cnt_nxt = r_cnt - CNT_ONE;
          if (r_cnt > CNT_ONE) w_multi_stall = 1'b1;
          else                 w_state_nxt   = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Pipeline register controls by priority; branch/load-use ignored in MULTI
  always_comb begin
    pc_write_o     = 1'b0;
    ifid_write_o   = 1'b0;
    ifid_flush_o   = 1'b0;
    idex_write_o   = 1'b0;
    idex_bubble_o  = 1'b0;
    exmem_bubble_o = 1'b0;
    if (w_active) begin
      if (w_multi_stall) begin
        exmem_bubble_o = 1'b1;
      end else if ((r_state == IDLE) && w_flush_req) begin
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b1;
        idex_write_o  = 1'b1;
        idex_bubble_o = 1'b1;
      end else if ((r_state == IDLE) && w_load_use) begin
        idex_write_o  = 1'b1;
        idex_bubble_o = 1'b1;
      end else begin
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        idex_write_o = 1'b1;
      end
    end
  end

  // Saturating count of stalled run cycles
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cycles <= '0;
    end else if (start_i && !pc_write_o && (r_stall_cycles != '1)) begin
      r_stall_cycles <= r_stall_cycles + 1'b1;
    end
  end

  assign busy_o         = (r_state == MULTI);
  assign stall_cycles_o = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Randomized + directed bench for pipeline_hazard_unit. Three instances with
// different MULDIV_LAT/CNT_W share one input set and one behavioural model.
module tb_pipeline_hazard_unit;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
  logic       id_uses_rt, ex_memread, ex_multi, mem_rw, wb_rw, br, jmp;

  logic       pc_w[3], ifid_w[3], ifid_f[3], idex_w[3], idex_b[3], exm_b[3], busy[3];
  logic [1:0] fa[3], fb[3];
  logic [15:0] sc0;
  logic [3:0]  sc1, sc2;

  int n_cmp = 0;
  int n_err = 0;

  // Model parameters and state per instance
  int LAT[3]   = '{4, 1, 2};
  int SCMAX[3] = '{65535, 15, 15};
  int left[3];   // remaining cycles the multi-cycle op occupies EX after its first
  int sc[3];     // expected stall counter

  always #5 clk = ~clk;

  pipeline_hazard_unit #(.REG_ADDR_W(5), .MULDIV_LAT(4), .CNT_W(16)) dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_uses_rt_i(id_uses_rt), .ex_rs_i(ex_rs), .ex_rt_i(ex_rt), .ex_rd_i(ex_rd),
    .ex_memread_i(ex_memread), .ex_multi_i(ex_multi), .mem_rd_i(mem_rd),
    .mem_regwrite_i(mem_rw), .wb_rd_i(wb_rd), .wb_regwrite_i(wb_rw),
    .branch_taken_i(br), .jump_i(jmp), .pc_write_o(pc_w[0]), .ifid_write_o(ifid_w[0]),
    .ifid_flush_o(ifid_f[0]), .idex_write_o(idex_w[0]), .idex_bubble_o(idex_b[0]),
    .exmem_bubble_o(exm_b[0]), .fwd_a_o(fa[0]), .fwd_b_o(fb[0]), .busy_o(busy[0]),
    .stall_cycles_o(sc0));

  pipeline_hazard_unit #(.REG_ADDR_W(5), .MULDIV_LAT(1), .CNT_W(4)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_uses_rt_i(id_uses_rt), .ex_rs_i(ex_rs), .ex_rt_i(ex_rt), .ex_rd_i(ex_rd),
    .ex_memread_i(ex_memread), .ex_multi_i(ex_multi), .mem_rd_i(mem_rd),
    .mem_regwrite_i(mem_rw), .wb_rd_i(wb_rd), .wb_regwrite_i(wb_rw),
    .branch_taken_i(br), .jump_i(jmp), .pc_write_o(pc_w[1]), .ifid_write_o(ifid_w[1]),
    .ifid_flush_o(ifid_f[1]), .idex_write_o(idex_w[1]), .idex_bubble_o(idex_b[1]),
    .exmem_bubble_o(exm_b[1]), .fwd_a_o(fa[1]), .fwd_b_o(fb[1]), .busy_o(busy[1]),
    .stall_cycles_o(sc1));

  pipeline_hazard_unit #(.REG_ADDR_W(5), .MULDIV_LAT(2), .CNT_W(4)) dut2 (
    .clk_i(clk), .rst_i(rst), .start_i(start), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_uses_rt_i(id_uses_rt), .ex_rs_i(ex_rs), .ex_rt_i(ex_rt), .ex_rd_i(ex_rd),
    .ex_memread_i(ex_memread), .ex_multi_i(ex_multi), .mem_rd_i(mem_rd),
    .mem_regwrite_i(mem_rw), .wb_rd_i(wb_rd), .wb_regwrite_i(wb_rw),
    .branch_taken_i(br), .jump_i(jmp), .pc_write_o(pc_w[2]), .ifid_write_o(ifid_w[2]),
    .ifid_flush_o(ifid_f[2]), .idex_write_o(idex_w[2]), .idex_bubble_o(idex_b[2]),
    .exmem_bubble_o(exm_b[2]), .fwd_a_o(fa[2]), .fwd_b_o(fb[2]), .busy_o(busy[2]),
    .stall_cycles_o(sc2));

  task automatic check(input string name, input int k, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s[%0d] got=%0h expected=%0h t=%0t", name, k, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_fwd(input logic [4:0] src);
    if (!(!rst && start))                            return 2'b00;
    if (mem_rw && mem_rd != 5'd0 && mem_rd == src)   return 2'b01;
    if (wb_rw && wb_rd != 5'd0 && wb_rd == src)      return 2'b10;
    return 2'b00;
  endfunction

  function automatic bit model_mstall(input int k);
    if (rst || !start) return 1'b0;
    if (left[k] == 0) return ex_multi && (LAT[k] > 1);
    return left[k] > 1;   // the op's final cycle in EX is not stalled
  endfunction

  // Expected control word {pc,ifid_w,ifid_f,idex_w,idex_b,exm_b,fa,fb,busy}
  function automatic logic [10:0] exp_out(input int k);
    bit act, ms, idle, fl, lu, luc;
    act  = !rst && start;
    ms   = model_mstall(k);
    idle = (left[k] == 0);
    luc  = ex_memread && ex_rd != 5'd0 &&
           (ex_rd == id_rs || (id_uses_rt && ex_rd == id_rt));
    fl   = act && idle && !ms && (br || jmp);
    lu   = act && idle && !ms && !fl && luc;
    return {act && !ms && !lu, act && !ms && !lu, fl, act && !ms, fl || lu, ms,
            model_fwd(ex_rs), model_fwd(ex_rt), left[k] > 0};
  endfunction

  function automatic logic [10:0] act_out(input int k);
    return {pc_w[k], ifid_w[k], ifid_f[k], idex_w[k], idex_b[k], exm_b[k],
            fa[k], fb[k], busy[k]};
  endfunction

  function automatic logic [31:0] act_sc(input int k);
    case (k)
      0:       return 32'(sc0);
      1:       return 32'(sc1);
      default: return 32'(sc2);
    endcase
  endfunction

  task automatic check_all();
    #1;
    for (int k = 0; k < 3; k++) begin
      check("ctl", k, 32'(act_out(k)), 32'(exp_out(k)));
      check("stall_cnt", k, act_sc(k), 32'(sc[k]));
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      left[k] = 0;
      sc[k]   = 0;
    end
  endtask

  // Advance model and DUT by one clock with the inputs currently applied
  task automatic tick();
    bit pc_exp[3];
    for (int k = 0; k < 3; k++) begin
      logic [10:0] e;
      e = exp_out(k);
      pc_exp[k] = e[10];
    end
    @(posedge clk);
    if (rst) model_reset();
    else if (start) begin
      for (int k = 0; k < 3; k++) begin
        if (!pc_exp[k] && sc[k] < SCMAX[k]) sc[k]++;
        if (left[k] > 0)                    left[k]--;
        else if (ex_multi && LAT[k] > 1)    left[k] = LAT[k] - 1;
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    start = 1'b1; id_rs = 0; id_rt = 0; id_uses_rt = 0; ex_rs = 0; ex_rt = 0;
    ex_rd = 0; ex_memread = 0; ex_multi = 0; mem_rd = 0; mem_rw = 0;
    wb_rd = 0; wb_rw = 0; br = 0; jmp = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    model_reset();
    check_all();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout reached");
    $fatal(1, "timeout");
  end

  initial begin
    int busy_n, stall_n[3];
    model_reset();
    clear_inputs();
    rst = 1'b1;
    #3;
    do_reset();

    // Forwarding: MEM beats WB, r0 never forwarded
    mem_rw = 1; mem_rd = 3; wb_rw = 1; wb_rd = 3; ex_rs = 3;
    check_all();
    check("fwd_a_mem_prio", 0, 32'(fa[0]), 32'h1);
    mem_rd = 0; wb_rd = 0; ex_rs = 0;
    check_all();
    check("fwd_a_r0", 0, 32'(fa[0]), 32'h0);
    wb_rd = 7; ex_rt = 7; mem_rd = 2;
    check_all();
    check("fwd_b_wb", 0, 32'(fb[0]), 32'h2);
    tick();

    // Load-use: one stall cycle
    do_reset();
    ex_memread = 1; ex_rd = 5; id_rs = 5;
    check_all();
    check("lu_pc_write", 0, 32'(pc_w[0]), 32'h0);
    check("lu_idex_bubble", 0, 32'(idex_b[0]), 32'h1);
    check("lu_cnt_before", 0, 32'(sc0), 32'h0);
    tick();
    check("lu_cnt_after", 0, 32'(sc0), 32'h1);

    // Flush overrides load-use
    br = 1;
    check_all();
    check("flush_pc_write", 0, 32'(pc_w[0]), 32'h1);
    check("flush_ifid", 0, 32'(ifid_f[0]), 32'h1);
    check("flush_bubble", 0, 32'(idex_b[0]), 32'h1);
    tick();
    check("flush_cnt", 0, 32'(sc0), 32'h1);

    // Multi-cycle op pulse
    do_reset();
    busy_n = 0;
    stall_n = '{0, 0, 0};
    ex_multi = 1;
    for (int c = 0; c < 8; c++) begin
      check_all();
      busy_n += int'(busy[0]);
      for (int k = 0; k < 3; k++) stall_n[k] += int'(!pc_w[k]);
      tick();
      ex_multi = 0;
    end
    check("multi_stalls_lat4", 0, 32'(stall_n[0]), 32'd3);
    check("multi_busy_lat4", 0, 32'(busy_n), 32'd3);
    check("multi_stalls_lat1", 1, 32'(stall_n[1]), 32'd0);
    check("multi_stalls_lat2", 2, 32'(stall_n[2]), 32'd1);

    // Asynchronous reset in the second MULTI cycle
    do_reset();
    ex_multi = 1;
    check_all();
    tick();
    ex_multi = 0;
    check_all();
    tick();
    check("busy_before_rst", 0, 32'(busy[0]), 32'h1);
    #2;
    rst = 1'b1;
    model_reset();
    check_all();
    check("busy_async_rst", 0, 32'(busy[0]), 32'h0);
    check("cnt_async_rst", 0, 32'(sc0), 32'h0);
    tick();
    rst = 1'b0;
    check_all();
    check("pc_after_rst", 0, 32'(pc_w[0]), 32'h1);
    tick();

    // Saturation of the 4-bit counter under a held load-use
    do_reset();
    ex_memread = 1; ex_rd = 5; id_rs = 5;
    for (int c = 0; c < 20; c++) begin
      check_all();
      tick();
    end
    check("sat_cw4", 1, 32'(sc1), 32'd15);
    check("nosat_cw16", 0, 32'(sc0), 32'd20);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst        = ($urandom_range(0, 79) == 0);
      start      = ($urandom_range(0, 7) != 0);
      id_rs      = 5'($urandom_range(0, 3));
      id_rt      = 5'($urandom_range(0, 3));
      id_uses_rt = 1'($urandom_range(0, 1));
      ex_rs      = 5'($urandom_range(0, 3));
      ex_rt      = 5'($urandom_range(0, 3));
      ex_rd      = 5'($urandom_range(0, 3));
      ex_memread = ($urandom_range(0, 2) == 0);
      ex_multi   = ($urandom_range(0, 5) == 0);
      mem_rd     = 5'($urandom_range(0, 3));
      mem_rw     = 1'($urandom_range(0, 1));
      wb_rd      = 5'($urandom_range(0, 3));
      wb_rw      = 1'($urandom_range(0, 1));
      br         = ($urandom_range(0, 6) == 0);
      jmp        = ($urandom_range(0, 9) == 0);
      if (rst) model_reset();
      check_all();
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
